// File: rtl/fp_add_rr_scheduler.sv
// fp_add_rr_scheduler: round-robin arbiter sharing one pipelined FP adder among NUM_REQ requesters.
// Ports: clk/rst (async, active-low); hold stops new grants; req_vld/req_a/req_b in, req_rdy one-hot grant;
// add_vld/add_a/add_b to the adder, add_result/add_state back; rsp_vld/rsp_result/rsp_state one-hot
// response after ADD_LAT+2 cycles; busy while any tag is in flight.
// Optional FP_ADD_SCHED_PERF_EN adds perf_clr and per-requester saturating grant counters perf_grant_cnt.
module fp_add_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 6,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [NUM_REQ-1:0][31:0]    req_a,
  input  logic [NUM_REQ-1:0][31:0]    req_b,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic                        add_vld,
  output logic [31:0]                 add_a,
  output logic [31:0]                 add_b,
  input  logic [31:0]                 add_result,
  input  logic [1:0]                  add_state,
  output logic [NUM_REQ-1:0]          rsp_vld,
  output logic [31:0]                 rsp_result,
  output logic [1:0]                  rsp_state,
`ifdef FP_ADD_SCHED_PERF_EN
  input  logic                        perf_clr,
  output logic [NUM_REQ-1:0][15:0]    perf_grant_cnt,
`endif
  output logic                        busy
);
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_id;
  logic found, xfer;
  logic add_vld_q, add_vld_d;
  logic [31:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [ADD_LAT:0] tv_q, tv_d;
  logic [ADD_LAT:0][ID_W-1:0] tid_q, tid_d;
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [1:0] rsp_state_q, rsp_state_d;
  // Search starts at ptr and wraps, so the first valid requester at or after ptr wins.
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_vld[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt_id = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    xfer = found & ~hold & rst;
    req_rdy = '0;
    req_rdy[gnt_id] = xfer;
  end
  always_comb begin
    ptr_d = xfer ? (gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1)) : ptr_q;
    add_vld_d = xfer;
    add_a_d = xfer ? req_a[gnt_id] : add_a_q;
    add_b_d = xfer ? req_b[gnt_id] : add_b_q;
    tv_d = {tv_q[ADD_LAT-1:0], xfer};
    tid_d = {tid_q[ADD_LAT-1:0], gnt_id};
    rsp_vld_d = '0;
    rsp_vld_d[tid_q[ADD_LAT]] = tv_q[ADD_LAT];
    // The last tag stage lines up with the adder output, so both are captured together.
    rsp_result_d = tv_q[ADD_LAT] ? add_result : rsp_result_q;
    rsp_state_d = tv_q[ADD_LAT] ? add_state : rsp_state_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      add_vld_q <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
      rsp_vld_q <= '0;
      rsp_result_q <= '0;
      rsp_state_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      add_vld_q <= add_vld_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      tv_q <= tv_d;
      tid_q <= tid_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_result_q <= rsp_result_d;
      rsp_state_q <= rsp_state_d;
    end
  end
  assign add_vld = add_vld_q;
  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_result = rsp_result_q;
  assign rsp_state = rsp_state_q;
  assign busy = |tv_q;
`ifdef FP_ADD_SCHED_PERF_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      cnt_d[i] = perf_clr ? '0 : (req_rdy[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign perf_grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fp_add_rr_scheduler.sv
// tb_fp_add_rr_scheduler: directed bench with an adder stub and a response scoreboard.
module tb_fp_add_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hold = 1'b0;
  logic [NUM_REQ-1:0] req_vld = '0;
  logic [NUM_REQ-1:0][31:0] req_a = '0, req_b = '0;
  logic [NUM_REQ-1:0] req_rdy, rsp_vld;
  logic add_vld, busy;
  logic [31:0] add_a, add_b, add_result, rsp_result;
  logic [1:0] add_state, rsp_state;
`ifdef FP_ADD_SCHED_PERF_EN
  logic perf_clr = 1'b0;
  logic [NUM_REQ-1:0][15:0] perf_grant_cnt;
`endif
  int n_tests = 0, n_fail = 0, cyc = 0;

  fp_add_rr_scheduler #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .add_vld(add_vld), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_state(add_state), .rsp_vld(rsp_vld),
    .rsp_result(rsp_result), .rsp_state(rsp_state),
`ifdef FP_ADD_SCHED_PERF_EN
    .perf_clr(perf_clr), .perf_grant_cnt(perf_grant_cnt),
`endif
    .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Adder stub: OK=00 NAN=01 INF=10 NUL=11; 1.0+2.0 is exact, other sums are a scrambled tag.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]};
  endfunction
  function automatic logic [1:0] fst(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;
    bi = b[30:23] == 8'hFF && b[22:0] == 0;
    return (an || bn) ? 2'b01 : (ai || bi) ? 2'b10 : (a[30:0] == 0 && b[30:0] == 0) ? 2'b11 : 2'b00;
  endfunction

  logic [31:0] pr [ADD_LAT];
  logic [1:0] ps [ADD_LAT];
  always @(posedge clk) begin
    pr[0] <= fadd(add_a, add_b);
    ps[0] <= fst(add_a, add_b);
    for (int i = 1; i < ADD_LAT; i++) begin
      pr[i] <= pr[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign add_result = pr[ADD_LAT-1];
  assign add_state = ps[ADD_LAT-1];

  typedef struct { int due; int id; logic [31:0] r; logic [1:0] s; } ent_t;
  ent_t sb [$];

  // Scoreboard: each transfer is due ADD_LAT+2 cycles later; a reset drops everything in flight.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_vld;
    #2;
    exp_vld = '0;
    if (!rst) sb.delete();
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_vld[sb[0].id] = 1'b1;
      chk("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
      chk("rsp_result", rsp_result, sb[0].r);
      chk("rsp_state", 32'(rsp_state), 32'(sb[0].s));
      void'(sb.pop_front());
    end else chk("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
    if (rst)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_vld[i] && req_rdy[i])
          sb.push_back('{cyc + ADD_LAT + 2, i, fadd(req_a[i], req_b[i]), fst(req_a[i], req_b[i])});
  end

  task automatic drive(input logic [3:0] vld, input logic h, input logic [3:0] exp,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_vld = vld;
    hold = h;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i] = a;
      req_b[i] = b;
    end
    #1 chk("req_rdy", 32'(req_rdy), 32'(exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  initial begin
    logic [3:0] order [8];
    logic [3:0] sk_v [4];
    logic [3:0] sk_g [4];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sk_v = '{4'b1111, 4'b1101, 4'b1011, 4'b1010};
    sk_g = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
    req_vld = 4'b1111;
    @(negedge clk);
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    chk("rst_add_vld", 32'(add_vld), 32'h0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_rsp_state", 32'(rsp_state), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req_vld = '0;
    idle(1);
    for (int n = 0; n < 8; n++) drive(4'b1111, 1'b0, order[n], 32'h41000000 + n, 32'h30000000 + n);
    idle(10);
    drive(4'b0010, 1'b0, 4'b0010, 32'h3F800000, 32'h40000000);
    drive(4'b0000, 1'b0, 4'b0000, 32'h0, 32'h0);
    chk("add_vld", 32'(add_vld), 32'h1);
    chk("add_a", add_a, 32'h3F800000);
    chk("add_b", add_b, 32'h40000000);
    chk("busy_on", 32'(busy), 32'h1);
    drive(4'b0000, 1'b0, 4'b0000, 32'h0, 32'h0);
    chk("add_vld_idle", 32'(add_vld), 32'h0);
    chk("add_a_hold", add_a, 32'h3F800000);
    for (int n = 0; n < 3; n++) drive(4'b1000, 1'b0, 4'b1000, 32'h42000000 + n, 32'h31000000);
    for (int n = 0; n < 3; n++) drive(4'b1111, 1'b0, order[n], 32'h43000000 + n, 32'h32000000);
    for (int n = 0; n < 3; n++) drive(4'b1111, 1'b1, 4'b0000, 32'h44000000 + n, 32'h33000000);
    drive(4'b1111, 1'b0, 4'b1000, 32'h45000000, 32'h34000000);
    idle(10);
    chk("busy_drained", 32'(busy), 32'h0);
    for (int n = 0; n < 4; n++) drive(sk_v[n], 1'b0, sk_g[n], 32'h46000000 + n, 32'h35000000 + n);
    drive(4'b0100, 1'b0, 4'b0100, 32'h7F800000, 32'h3F800000);
    idle(10);
    for (int n = 0; n < 3; n++) drive(4'b1111, 1'b0, {order[n][2:0], order[n][3]} == 4'b0 ? 4'b0 :
      (n == 0 ? 4'b1000 : n == 1 ? 4'b0001 : 4'b0010), 32'h47000000 + n, 32'h36000000);
    @(negedge clk);
    req_vld = '0;
    rst = 1'b0;
    #1;
    chk("rst_flight_busy", 32'(busy), 32'h0);
    chk("rst_flight_rsp", 32'(rsp_vld), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    drive(4'b1111, 1'b0, 4'b0001, 32'h48000000, 32'h37000000);
    idle(12);
`ifdef FP_ADD_SCHED_PERF_EN
    for (int n = 0; n < 70000; n++) drive(4'b0001, 1'b0, 4'b0001, 32'h49000000, 32'h38000000);
    idle(1);
    chk("perf_sat", 32'(perf_grant_cnt[0]), 32'hFFFF);
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1 chk("perf_clr", 32'(perf_grant_cnt[0]), 32'h0);
    idle(12);
`endif
    chk("drain", 32'(sb.size()), 32'h0);
    chk("busy_end", 32'(busy), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
